// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues single-word bus reads, holds the result for decode.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_enable,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data,
    input  logic                  mem_ack,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  fetch_misaligned
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    localparam logic [31:0] NOP = 32'h00000013;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    discard;
    logic [ADDR_WIDTH-1:0]   pc_nxt;
    logic                    trap_hit;
    logic                    trapped;
    logic                    can_go;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap_hit = redirect_valid && (redirect_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            trapped <= 1'b0;
        end else if (redirect_valid) begin
            trapped <= trap_hit;
        end
    end

    assign fetch_misaligned = trapped;
`else
    assign trap_hit = 1'b0;
    assign trapped  = 1'b0;
`endif

    // HOLD only advances on a handshake, so pc+4 is only consumed there
    always_comb begin
        pc_nxt = pc;
        if (redirect_valid) begin
            pc_nxt = redirect_addr;
        end else if (state == HOLD) begin
            pc_nxt = pc + ADDR_WIDTH'(4);
        end
    end

    assign can_go = fetch_enable && !trap_hit && !(trapped && !redirect_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            mem_rd      <= 1'b0;
            mem_addr    <= RESET_VECTOR;
            instr_valid <= 1'b0;
            instruction <= NOP;
            instr_pc    <= '0;
            discard     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    pc <= pc_nxt;
                    if (can_go) begin
                        state    <= REQ;
                        mem_rd   <= 1'b1;
                        mem_addr <= pc_nxt;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_rd <= 1'b0;
                        if (discard || redirect_valid) begin
                            discard <= 1'b0;
                            pc      <= pc_nxt;
                            state   <= IDLE;
                        end else begin
                            instruction <= mem_data;
                            instr_pc    <= mem_addr;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // bus read stays outstanding; its data is dropped on ack
                        pc      <= redirect_addr;
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid || instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc_nxt;
                        if (can_go) begin
                            state    <= REQ;
                            mem_rd   <= 1'b1;
                            mem_addr <= pc_nxt;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand sequences,
// then random traffic against a transaction-level PC/data model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_enable = 1'b0;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = 32'h0;
    logic        mem_ack = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    int nvec = 0;
    int nerr = 0;

    instruction_fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .fetch_enable(fetch_enable),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_ack(mem_ack),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instruction(instruction),
        .instr_pc(instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned(fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0013;
    endfunction

    typedef struct {
        logic        fe, ack, rv, rdy;
        logic [31:0] data, raddr;
        logic        e_rd, e_vld;
        logic [31:0] e_addr, e_ins, e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic fe, input logic ack, input logic [31:0] data,
        input logic rv, input logic [31:0] raddr, input logic rdy,
        input logic e_rd, input logic [31:0] e_addr, input logic e_vld,
        input logic [31:0] e_ins, input logic [31:0] e_pc);
        vec_t v;
        v.fe = fe; v.ack = ack; v.data = data; v.rv = rv;
        v.raddr = raddr; v.rdy = rdy; v.e_rd = e_rd; v.e_addr = e_addr;
        v.e_vld = e_vld; v.e_ins = e_ins; v.e_pc = e_pc;
        return v;
    endfunction

    localparam logic [31:0] D0 = 32'h00500093;
    localparam logic [31:0] D1 = 32'h00a00113;
    localparam logic [31:0] D2 = 32'h00000073;
    localparam logic [31:0] D3 = 32'h123450b7;
    localparam logic [31:0] D4 = 32'hfff00193;
    localparam logic [31:0] D5 = 32'h0040006f;
    localparam logic [31:0] BAD = 32'hdeadbeef;

    task automatic drive(input logic fe, input logic ack, input logic [31:0] data,
                         input logic rv, input logic [31:0] raddr, input logic rdy);
        fetch_enable = fe; mem_ack = ack; mem_data = data;
        redirect_valid = rv; redirect_addr = raddr; instr_ready = rdy;
        @(negedge clk);
    endtask

    int          accepted = 0;
    logic [31:0] exp_pc;
    logic        prev_rd;
    logic [31:0] prev_addr;
    logic        inprog;
    int          cnt;
    logic [31:0] rnd;

    initial begin
        // fe ack data rv raddr rdy | rd addr vld ins pc
        tbl.push_back(mk(1, 0, 0,   0, 0, 0,  1, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 1, D0,  0, 0, 0,  0, 32'h0, 1, D0, 32'h0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 32'h0, 1, D0, 32'h0));
        tbl.push_back(mk(1, 0, 0,   0, 0, 1,  1, 32'h4, 0, 0, 0));
        tbl.push_back(mk(1, 1, D1,  0, 0, 0,  0, 32'h4, 1, D1, 32'h4));
        tbl.push_back(mk(1, 0, 0,   0, 0, 1,  1, 32'h8, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   1, 32'h100, 0,  1, 32'h8, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   0, 0, 0,  1, 32'h8, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   0, 0, 0,  1, 32'h8, 0, 0, 0));
        tbl.push_back(mk(1, 1, BAD, 0, 0, 0,  0, 32'h8, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   0, 0, 0,  1, 32'h100, 0, 0, 0));
        tbl.push_back(mk(1, 1, D2,  0, 0, 0,  0, 32'h100, 1, D2, 32'h100));
        tbl.push_back(mk(1, 0, 0,   1, 32'h40, 1,  1, 32'h40, 0, 0, 0));
        tbl.push_back(mk(1, 1, D3,  0, 0, 0,  0, 32'h40, 1, D3, 32'h40));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1,  0, 32'h40, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 0,  0, 32'h40, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   0, 0, 0,  1, 32'h44, 0, 0, 0));
        tbl.push_back(mk(1, 1, BAD, 1, 32'h200, 0,  0, 32'h44, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   0, 0, 0,  1, 32'h200, 0, 0, 0));
        tbl.push_back(mk(1, 1, D4,  0, 0, 0,  0, 32'h200, 1, D4, 32'h200));
        tbl.push_back(mk(1, 0, 0,   0, 0, 1,  1, 32'h204, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   1, 32'hfffffffc, 0,  1, 32'h204, 0, 0, 0));
        tbl.push_back(mk(1, 1, BAD, 0, 0, 0,  0, 32'h204, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   0, 0, 0,  1, 32'hfffffffc, 0, 0, 0));
        tbl.push_back(mk(1, 1, D5,  0, 0, 0,  0, 32'hfffffffc, 1, D5, 32'hfffffffc));
        tbl.push_back(mk(1, 0, 0,   0, 0, 1,  1, 32'h0, 0, 0, 0));
        tbl.push_back(mk(1, 1, D0,  0, 0, 0,  0, 32'h0, 1, D0, 32'h0));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1,  0, 32'h0, 0, 0, 0));

        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instruction, 32'h00000013);
        chk("rst_pc", instr_pc, 32'h0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].fe, tbl[i].ack, tbl[i].data,
                  tbl[i].rv, tbl[i].raddr, tbl[i].rdy);
            chk($sformatf("v%0d_rd", i), {31'b0, mem_rd}, {31'b0, tbl[i].e_rd});
            chk($sformatf("v%0d_vld", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_vld});
            if (tbl[i].e_rd)
                chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].e_addr);
            if (tbl[i].e_vld) begin
                chk($sformatf("v%0d_ins", i), instruction, tbl[i].e_ins);
                chk($sformatf("v%0d_pc", i), instr_pc, tbl[i].e_pc);
            end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        drive(1, 0, 0, 1, 32'h102, 0);
        chk("mis_flag_set", {31'b0, fetch_misaligned}, 32'h1);
        chk("mis_no_rd", {31'b0, mem_rd}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk("mis_stuck_rd", {31'b0, mem_rd}, 32'h0);
            chk("mis_stuck_flag", {31'b0, fetch_misaligned}, 32'h1);
        end
        drive(1, 0, 0, 1, 32'h104, 0);
        chk("mis_flag_clr", {31'b0, fetch_misaligned}, 32'h0);
        chk("mis_rd", {31'b0, mem_rd}, 32'h1);
        chk("mis_addr", mem_addr, 32'h104);
        drive(1, 1, D1, 0, 0, 0);
        chk("mis_vld", {31'b0, instr_valid}, 32'h1);
        drive(0, 0, 0, 0, 0, 1);
`endif

        // reset beats a same-cycle ack
        drive(1, 0, 0, 0, 0, 0);
        chk("rq_rd", {31'b0, mem_rd}, 32'h1);
        reset = 1'b1;
        drive(1, 1, BAD, 0, 0, 0);
        reset = 1'b0;
        chk("rq_rst_rd", {31'b0, mem_rd}, 32'h0);
        chk("rq_rst_vld", {31'b0, instr_valid}, 32'h0);
        chk("rq_rst_ins", instruction, 32'h00000013);
        drive(0, 0, 0, 0, 0, 0);
        chk("rq_idle_rd", {31'b0, mem_rd}, 32'h0);
        chk("rq_idle_vld", {31'b0, instr_valid}, 32'h0);
        drive(1, 0, 0, 0, 0, 0);
        chk("rq_vec_rd", {31'b0, mem_rd}, 32'h1);
        chk("rq_vec_addr", mem_addr, 32'h0);

        // random traffic; exp_pc is the next PC decode should see
        exp_pc = 32'h0;
        prev_rd = 1'b1;
        prev_addr = 32'h0;
        inprog = 1'b0;
        cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (instr_valid) begin
                chk("rnd_pc", instr_pc, exp_pc);
                chk("rnd_ins", instruction, memf(instr_pc));
                chk("rnd_rd_in_hold", {31'b0, mem_rd}, 32'h0);
            end
            if (mem_rd && !prev_rd)
                chk("rnd_req_addr", mem_addr, exp_pc);
            if (mem_rd && prev_rd)
                chk("rnd_addr_stable", mem_addr, prev_addr);
            prev_rd = mem_rd;
            prev_addr = mem_addr;

            mem_ack = 1'b0;
            mem_data = $urandom;
            if (mem_rd) begin
                if (!inprog) begin
                    inprog = 1'b1;
                    cnt = $urandom_range(0, 3);
                end
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_data = memf(mem_addr);
                    inprog = 1'b0;
                end else begin
                    cnt--;
                end
            end
            rnd = $urandom;
            fetch_enable = (rnd[1:0] != 2'b00);
            instr_ready = rnd[2];
            redirect_valid = (rnd[7:4] == 4'h0);
            redirect_addr = $urandom & 32'h0000fffc;

            if (redirect_valid) begin
                exp_pc = redirect_addr;
            end else if (instr_valid && instr_ready) begin
                exp_pc = instr_pc + 32'd4;
                accepted++;
            end
            @(negedge clk);
        end
        chk("rnd_progress", {31'b0, accepted > 100}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
